// File: rtl/pipe_pkg.sv
// Shared types for the generic pipeline stage register.
package pipe_pkg;

    localparam int unsigned OCC_W = 2;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} pipe_state_t;

endpackage

// File: rtl/pipe_slot.sv
// One valid+data storage slot. Load wins over clear. Data only changes on load.
module pipe_slot #(
    parameter int unsigned DATA_W = 160
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (clear_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with valid/ready handshake, optional skid entry,
// synchronous flush and a capture-time override of one payload field.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W  = 160,
    parameter int unsigned SKID    = 1,
    parameter int unsigned BYP_LSB = 64,
    parameter int unsigned BYP_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              byp_en,
    input  logic [BYP_W-1:0]  byp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [OCC_W-1:0]  occupancy
);

    function automatic logic [DATA_W-1:0] byp_merge(input logic [DATA_W-1:0] d,
                                                    input logic [BYP_W-1:0]  f,
                                                    input logic              en);
        logic [DATA_W-1:0] mask;
        logic [DATA_W-1:0] fld;
        mask = '0;
        fld  = '0;
        mask[BYP_LSB +: BYP_W] = '1;
        fld[BYP_LSB +: BYP_W]  = f;
        return en ? ((d & ~mask) | fld) : d;
    endfunction

    logic              accept, pop;
    logic              main_load, main_clear, main_valid;
    logic              skid_valid;
    logic [DATA_W-1:0] cap_data, main_din, main_data;

    assign cap_data = byp_merge(in_data, byp_data, byp_en);
    assign accept   = in_valid & in_ready & ~flush;
    assign pop      = out_valid & out_ready;

    pipe_slot #(
        .DATA_W (DATA_W)
    ) u_main (
        .clk     (clk),
        .rst     (rst),
        .load_i  (main_load),
        .clear_i (main_clear),
        .data_i  (main_din),
        .valid_o (main_valid),
        .data_o  (main_data)
    );

    if (SKID != 0) begin : g_skid
        pipe_state_t       state_q, state_d;
        logic              skid_load, skid_clear;
        logic [DATA_W-1:0] skid_data;

        always_comb begin
            state_d    = state_q;
            main_load  = 1'b0;
            main_clear = 1'b0;
            skid_load  = 1'b0;
            skid_clear = 1'b0;
            main_din   = cap_data;
            if (flush) begin
                // A pop on this cycle still completes; only storage is squashed.
                state_d    = EMPTY;
                main_clear = 1'b1;
                skid_clear = 1'b1;
            end else begin
                unique case (state_q)
                    EMPTY: begin
                        if (accept) begin
                            main_load = 1'b1;
                            state_d   = ONE;
                        end
                    end
                    ONE: begin
                        if (accept && pop) begin
                            main_load = 1'b1;
                        end else if (accept) begin
                            skid_load = 1'b1;
                            state_d   = FULL;
                        end else if (pop) begin
                            main_clear = 1'b1;
                            state_d    = EMPTY;
                        end
                    end
                    FULL: begin
                        if (pop) begin
                            main_load  = 1'b1;
                            main_din   = skid_data;
                            skid_clear = 1'b1;
                            state_d    = ONE;
                        end
                    end
                    default: state_d = EMPTY;
                endcase
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= EMPTY;
            end else begin
                state_q <= state_d;
            end
        end

        pipe_slot #(
            .DATA_W (DATA_W)
        ) u_skid (
            .clk     (clk),
            .rst     (rst),
            .load_i  (skid_load),
            .clear_i (skid_clear),
            .data_i  (cap_data),
            .valid_o (skid_valid),
            .data_o  (skid_data)
        );

        // Registered: no combinational path from out_ready.
        assign in_ready = ~skid_valid;
    end else begin : g_single
        always_comb begin
            main_load  = accept;
            main_clear = flush | pop;
            main_din   = cap_data;
        end

        assign skid_valid = 1'b0;
        assign in_ready   = ~main_valid | out_ready;
    end

    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign occupancy = OCC_W'(main_valid) + OCC_W'(skid_valid);

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: a SKID=1 instance and a SKID=0 instance
// share all inputs; each has its own outputs.
module tb_pipe_stage_skid;

    logic         clk;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic [159:0] in_data;
    logic         byp_en;
    logic [31:0]  byp_data;
    logic         out_ready;

    logic         in_ready1, out_valid1;
    logic [159:0] out_data1;
    logic [1:0]   occ1;
    logic         in_ready0, out_valid0;
    logic [159:0] out_data0;
    logic [1:0]   occ0;

    int n_cmp;
    int n_err;

    logic [159:0] exp_v;

    pipe_stage_skid #(
        .DATA_W  (160),
        .SKID    (1),
        .BYP_LSB (64),
        .BYP_W   (32)
    ) dut1 (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .in_data   (in_data),
        .byp_en    (byp_en),
        .byp_data  (byp_data),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .out_data  (out_data1),
        .occupancy (occ1)
    );

    pipe_stage_skid #(
        .DATA_W  (160),
        .SKID    (0),
        .BYP_LSB (64),
        .BYP_W   (32)
    ) dut0 (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready0),
        .in_data   (in_data),
        .byp_en    (byp_en),
        .byp_data  (byp_data),
        .out_valid (out_valid0),
        .out_ready (out_ready),
        .out_data  (out_data0),
        .occupancy (occ0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 160'h99;
        byp_en    = 1'b0;
        byp_data  = '0;
        out_ready = 1'b1;

        // Reset, with a beat presented that must be ignored
        tick();
        tick();
        check("rst_out_valid", out_valid1, 1'b0);
        check("rst_out_data", out_data1, '0);
        check("rst_occ", occ1, 2'd0);
        check("rst_in_ready", in_ready1, 1'b1);
        check("rst_in_ready0", in_ready0, 1'b1);
        in_valid = 1'b0;
        rst      = 1'b0;
        tick();
        check("post_rst_out_valid", out_valid1, 1'b0);

        // Streaming 1..8
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 160'(i);
            tick();
            check($sformatf("stream_valid_%0d", i), out_valid1, 1'b1);
            check($sformatf("stream_data_%0d", i), out_data1, 160'(i));
            check($sformatf("stream_in_ready_%0d", i), in_ready1, 1'b1);
        end
        in_valid = 1'b0;
        tick();
        check("stream_drained", out_valid1, 1'b0);

        // Backpressure: A, B stored; C held upstream
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 160'hA;
        tick();
        in_data = 160'hB;
        tick();
        check("bp_occ_full", occ1, 2'd2);
        check("bp_in_ready_low", in_ready1, 1'b0);
        check("bp_head_a", out_data1, 160'hA);
        in_data = 160'hC;
        tick();
        check("bp_hold_occ", occ1, 2'd2);
        check("bp_hold_head", out_data1, 160'hA);
        out_ready = 1'b1;
        tick();
        check("bp_pop_b", out_data1, 160'hB);
        check("bp_pop_occ", occ1, 2'd1);
        check("bp_in_ready_up", in_ready1, 1'b1);
        tick();
        check("bp_c_data", out_data1, 160'hC);
        check("bp_c_occ", occ1, 2'd1);
        in_valid = 1'b0;
        tick();
        check("bp_drained", out_valid1, 1'b0);

        // Bypass override on zero payload
        in_valid = 1'b1;
        in_data  = '0;
        byp_en   = 1'b1;
        byp_data = 32'hDEADBEEF;
        tick();
        exp_v          = '0;
        exp_v[95:64]   = 32'hDEADBEEF;
        check("byp_zero", out_data1, exp_v);
        in_valid  = 1'b0;
        byp_data  = 32'h12345678;
        out_ready = 1'b0;
        tick();
        check("byp_no_accept_data", out_data1, exp_v);
        check("byp_no_accept_valid", out_valid1, 1'b1);
        out_ready = 1'b1;
        tick();
        // Bypass clearing a field inside an all-ones payload
        in_valid = 1'b1;
        in_data  = '1;
        byp_data = 32'h0;
        tick();
        exp_v        = '1;
        exp_v[95:64] = 32'h0;
        check("byp_ones", out_data1, exp_v);
        byp_en   = 1'b0;
        in_valid = 1'b0;
        tick();

        // Flush while FULL with an incoming beat
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 160'h1;
        tick();
        in_data = 160'h2;
        tick();
        check("fl_full", occ1, 2'd2);
        flush   = 1'b1;
        in_data = 160'h3;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_out_valid", out_valid1, 1'b0);
        check("fl_occ", occ1, 2'd0);
        check("fl_in_ready", in_ready1, 1'b1);
        check("fl_data_held", out_data1, 160'h1);
        out_ready = 1'b1;
        tick();
        tick();
        check("fl_no_ghost", out_valid1, 1'b0);

        // Asynchronous reset mid-stream while FULL
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 160'h11;
        tick();
        in_data = 160'h22;
        tick();
        in_valid = 1'b0;
        check("ar_full", occ1, 2'd2);
        #2;
        rst = 1'b1;
        #1;
        check("ar_out_valid", out_valid1, 1'b0);
        check("ar_occ", occ1, 2'd0);
        check("ar_out_data", out_data1, '0);
        check("ar_in_ready", in_ready1, 1'b1);
        #1;
        rst = 1'b0;
        tick();
        in_valid  = 1'b1;
        in_data   = 160'h5;
        out_ready = 1'b1;
        tick();
        check("ar_beat5_valid", out_valid1, 1'b1);
        check("ar_beat5_data", out_data1, 160'h5);
        in_valid = 1'b0;
        tick();
        check("ar_beat5_gone", out_valid1, 1'b0);

        // SKID=0 instance
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 160'h7;
        #1;
        check("s0_ready_empty", in_ready0, 1'b1);
        tick();
        check("s0_valid7", out_valid0, 1'b1);
        check("s0_data7", out_data0, 160'h7);
        check("s0_occ1", occ0, 2'd1);
        in_data = 160'h8;
        #1;
        check("s0_ready_blocked", in_ready0, 1'b0);
        tick();
        check("s0_hold7", out_data0, 160'h7);
        out_ready = 1'b1;
        #1;
        check("s0_ready_comb", in_ready0, 1'b1);
        tick();
        check("s0_data8", out_data0, 160'h8);
        check("s0_occ_stays", occ0, 2'd1);
        in_valid = 1'b0;
        tick();
        check("s0_drained_valid", out_valid0, 1'b0);
        check("s0_drained_occ", occ0, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline-stage register with valid/ready handshake, optional skid entry, synchronous flush and a capture-time bypass field override. It replaces the fixed-field, always-advancing stage registers between core pipeline stages (e.g. MEM→WB) with one generic block. The stage carries an opaque packed payload. Stalls propagate by backpressure instead of by holding the clock.

## Interface
Parameters:
- DATA_W, 160: payload width in bits (packed stage fields).
- SKID, 1: 1 = two-entry (main + skid) with registered in_ready; 0 = single entry with combinational in_ready.
- BYP_LSB, 64: LSB of the payload field that the bypass can override.
- BYP_W, 32: width of the overridable field; BYP_LSB+BYP_W ≤ DATA_W.

Ports (reset rst, asynchronous, active-high; clock clk):
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- flush  in  1  synchronous squash of all stored and incoming beats.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat.
- in_data  in  DATA_W  upstream payload.
- byp_en  in  1  replace the bypass field of the captured beat.
- byp_data  in  BYP_W  replacement field value (e.g. store data on a store→load hazard).
- out_valid  out  1  downstream beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  downstream payload.
- occupancy  out  2  number of stored beats (0..2; max 1 when SKID=0).

## Operation
- Accept = in_valid & in_ready & !flush. Pop = out_valid & out_ready.
- Captured payload = in_data with bits [BYP_LSB +: BYP_W] replaced by byp_data if byp_en. byp_en is sampled only on the accept cycle.
- out_valid = main.valid, out_data = main.data.
- SKID=1, states EMPTY (M0,S0), ONE (M1,S0), FULL (M1,S1):
  - EMPTY: accept → ONE (M←in); otherwise stay.
  - ONE: accept&pop → ONE (M←in); accept&!pop → FULL (S←in); !accept&pop → EMPTY; neither → hold.
  - FULL: in_ready=0, so no accept. Pop → ONE (M←S); otherwise hold.
  - in_ready = !S.valid, driven from a register (no combinational path from out_ready).
- SKID=0: in_ready = !M.valid | out_ready (combinational). Accept → M←in; pop without accept → M.valid=0.
- Flush: next state EMPTY. All valids clear and the incoming beat is dropped, even if in_valid&in_ready. A pop on the flush cycle still completes, since downstream saw a valid beat. Flush has priority over accept and over the skid→main move.
- Data registers load only on capture/move. They hold their last value when invalid and are not cleared by flush.
- Beat order is preserved: main is always older than skid.

## Timing
- Reset: out_valid=0, out_data=0, occupancy=0, skid data/valid=0, in_ready=1 (SKID=1, registered) / 1 (SKID=0, M empty). Beats presented while rst=1 are ignored.
- Latency: an accept at edge N gives out_valid=1 with that beat after edge N (visible in cycle N+1).
- Throughput: 1 beat/cycle sustained in both modes while out_ready=1.
- SKID=1: in_ready drops the cycle after FULL is entered and rises the cycle after the pop from FULL.
- Reset mid-operation: all state cleared immediately and asynchronously, with the reset values above. No beat survives.
- out_ready toggling while out_valid=0 has no effect.

## Structure
- Package pipe_pkg: state enum pipe_state_t {EMPTY, ONE, FULL} and occupancy width constant OCC_W=2.
- Sub-module pipe_slot (params DATA_W): one valid+data register with load, clear and async reset. It is instantiated as main and skid; with SKID=0 only main is instantiated.
- The bypass merge is a local mask function, not a module.

## Test plan
- Streaming: SKID=1, out_ready=1, in_data=1..8 back-to-back → out_data=1..8 in order, one per cycle, each 1 cycle after accept; in_ready stays 1.
- Backpressure: out_ready=0, send 0xA then 0xB → occupancy=2 and in_ready=0 from the next cycle; 0xC held upstream. Release out_ready → 0xA, 0xB, 0xC in order with no loss or duplication.
- Bypass: in_data=0, byp_en=1, byp_data=0xDEADBEEF, BYP_LSB=64 → out_data[95:64]=0xDEADBEEF and all other bits 0. byp_en=1 with no accept → no change.
- Flush: FULL state with flush=1 and in_valid=1 → next cycle out_valid=0, occupancy=0, in_ready=1, incoming beat never appears.
- Async reset mid-stream: assert rst between edges while FULL → out_valid=0, occupancy=0 and out_data=0 immediately. Deassert and stream 0x5 → it appears 1 cycle after accept.
- SKID=0 mode: out_ready=0 with one beat stored → in_ready=0 combinationally. Raise out_ready in the same cycle as in_valid → in_ready=1, beat replaces main, occupancy stays 1.
